// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: commit-trace ring buffer, halt detector and run counters.
// Latency: capture/counters/halt visible the cycle after the commit; reads return 1 cycle after rd_req.
// Backpressure: none; every commit is snooped and every rd_req gets exactly one response.
//
// Ports:
//   clk, reset                       clock (rising edge), synchronous active-high reset
//   commit_valid/pc/instr/we/rd/wdata retiring-instruction snoop from the core
//   trace_en                          1 = record commits into the ring buffer
//   rd_req, rd_idx                    trace read request; rd_idx 0 = oldest held entry
//   rd_valid, rd_miss, rd_*           registered read response
//   entries, overflow                 fill level and sticky overwrite flag
//   halted, halt_pc                   sticky halt flag and PC of the halting commit
//   cycle_count, instr_count          saturating run counters, frozen after halt
module cpu_trace_monitor #(
  parameter int          XLEN       = 64,
  parameter int          DEPTH      = 16,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0000,
  parameter int          HALT_COUNT = 1,
  parameter int          CNT_W      = 32,
  localparam int         AW         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             commit_valid,
  input  logic [XLEN-1:0]  commit_pc,
  input  logic [31:0]      commit_instr,
  input  logic             commit_we,
  input  logic [4:0]       commit_rd,
  input  logic [XLEN-1:0]  commit_wdata,
  input  logic             trace_en,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_idx,
  output logic             rd_valid,
  output logic             rd_miss,
  output logic [XLEN-1:0]  rd_pc,
  output logic [XLEN-1:0]  rd_wdata,
  output logic [31:0]      rd_instr,
  output logic             rd_we,
  output logic [4:0]       rd_rd,
  output logic [AW:0]      entries,
  output logic             overflow,
  output logic             halted,
  output logic [XLEN-1:0]  halt_pc,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  // Run counter only ever needs to hold 0..HALT_COUNT-1; reaching HALT_COUNT halts.
  localparam int RW = $clog2(HALT_COUNT + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
  } entry_t;

  entry_t          trace_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [RW-1:0]   run_q;

  logic            capture;
  logic            commit_live;
  logic            is_halt_instr;
  logic            halt_hit;
  logic            rd_hit;
  logic [AW-1:0]   rd_phys;
  entry_t          rd_ent;

  always_comb begin
    commit_live   = commit_valid && !halted;
    capture       = commit_live && trace_en;
    is_halt_instr = (commit_instr == HALT_INSTR);
    halt_hit      = commit_live && is_halt_instr && (run_q == RW'(HALT_COUNT - 1));
    // Oldest entry sits entries slots behind wr_ptr; when full, entries[AW-1:0]
    // is 0 so the oldest is wr_ptr itself. Uses pre-capture state.
    rd_hit        = ({1'b0, rd_idx} < entries);
    rd_phys       = wr_ptr - entries[AW-1:0] + rd_idx;
    rd_ent        = trace_mem[rd_phys];
  end

  // Buffer storage carries no reset; validity is tracked by entries.
  always_ff @(posedge clk) begin
    if (!reset && capture) begin
      trace_mem[wr_ptr] <= '{pc: commit_pc, instr: commit_instr, we: commit_we,
                             rd: commit_rd, wdata: commit_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      entries     <= '0;
      run_q       <= '0;
      overflow    <= 1'b0;
      halted      <= 1'b0;
      halt_pc     <= '0;
      cycle_count <= '0;
      instr_count <= '0;
      rd_valid    <= 1'b0;
      rd_miss     <= 1'b0;
      rd_pc       <= '0;
      rd_wdata    <= '0;
      rd_instr    <= '0;
      rd_we       <= 1'b0;
      rd_rd       <= '0;
    end else begin
      if (capture) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (entries == (AW+1)'(DEPTH)) begin
          overflow <= 1'b1;
        end else begin
          entries <= entries + (AW+1)'(1);
        end
      end

      if (commit_live) begin
        if (instr_count != '1) begin
          instr_count <= instr_count + CNT_W'(1);
        end
        if (!is_halt_instr) begin
          run_q <= '0;
        end else if (!halt_hit) begin
          run_q <= run_q + RW'(1);
        end
      end

      if (halt_hit) begin
        halted  <= 1'b1;
        halt_pc <= commit_pc;
      end

      // Counts the halting cycle too, since halted is still 0 during it.
      if (!halted && cycle_count != '1) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end

      rd_valid <= rd_req;
      if (rd_req) begin
        rd_miss <= !rd_hit;
        if (rd_hit) begin
          rd_pc    <= rd_ent.pc;
          rd_wdata <= rd_ent.wdata;
          rd_instr <= rd_ent.instr;
          rd_we    <= rd_ent.we;
          rd_rd    <= rd_ent.rd;
        end else begin
          rd_pc    <= '0;
          rd_wdata <= '0;
          rd_instr <= '0;
          rd_we    <= 1'b0;
          rd_rd    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// tb_cpu_trace_monitor: directed bench for cpu_trace_monitor (DEPTH=16, HALT_COUNT=2).
// Latency: drives inputs 1 time unit after each rising edge and samples outputs there.
// Backpressure: none; the bench issues commits and reads at will.
module tb_cpu_trace_monitor;

  localparam int XLEN = 64;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             reset;
  logic             commit_valid;
  logic [XLEN-1:0]  commit_pc;
  logic [31:0]      commit_instr;
  logic             commit_we;
  logic [4:0]       commit_rd;
  logic [XLEN-1:0]  commit_wdata;
  logic             trace_en;
  logic             rd_req;
  logic [AW-1:0]    rd_idx;
  logic             rd_valid;
  logic             rd_miss;
  logic [XLEN-1:0]  rd_pc;
  logic [XLEN-1:0]  rd_wdata;
  logic [31:0]      rd_instr;
  logic             rd_we;
  logic [4:0]       rd_rd;
  logic [AW:0]      entries;
  logic             overflow;
  logic             halted;
  logic [XLEN-1:0]  halt_pc;
  logic [31:0]      cycle_count;
  logic [31:0]      instr_count;

  int errors = 0;
  int checks = 0;
  int exp_cyc = 0;
  bit exp_halted = 1'b0;

  cpu_trace_monitor #(
    .XLEN(XLEN), .DEPTH(DEPTH), .HALT_INSTR(HALT), .HALT_COUNT(2), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .commit_we(commit_we), .commit_rd(commit_rd), .commit_wdata(commit_wdata),
    .trace_en(trace_en), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_miss(rd_miss), .rd_pc(rd_pc), .rd_wdata(rd_wdata),
    .rd_instr(rd_instr), .rd_we(rd_we), .rd_rd(rd_rd),
    .entries(entries), .overflow(overflow), .halted(halted), .halt_pc(halt_pc),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; the cycle-count model tracks what the DUT should have counted.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      exp_cyc = 0;
      exp_halted = 1'b0;
    end else if (!exp_halted) begin
      exp_cyc++;
    end
    #1;
  endtask

  // Commit fields derived from pc: rd = pc/4 + 1, wdata = pc*3 + 7, we = 1.
  task automatic drive_commit(input logic [63:0] pc, input logic [31:0] instr);
    commit_valid = 1'b1;
    commit_pc    = pc;
    commit_instr = instr;
    commit_we    = 1'b1;
    commit_rd    = 5'(pc[6:2] + 5'd1);
    commit_wdata = pc * 3 + 7;
  endtask

  task automatic commit(input logic [63:0] pc, input logic [31:0] instr);
    drive_commit(pc, instr);
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic read(input int idx);
    rd_req = 1'b1;
    rd_idx = AW'(idx);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic chk_hit(input string tag, input logic [63:0] pc, input logic [31:0] instr);
    chk({tag, ".valid"}, 64'(rd_valid), 64'd1);
    chk({tag, ".miss"}, 64'(rd_miss), 64'd0);
    chk({tag, ".pc"}, rd_pc, pc);
    chk({tag, ".wdata"}, rd_wdata, pc * 3 + 7);
    chk({tag, ".instr"}, 64'(rd_instr), 64'(instr));
    chk({tag, ".rd"}, 64'(rd_rd), 64'(pc[6:2] + 5'd1));
    chk({tag, ".we"}, 64'(rd_we), 64'd1);
  endtask

  initial begin
    reset = 1'b1; commit_valid = 1'b0; commit_pc = '0; commit_instr = ADDI;
    commit_we = 1'b0; commit_rd = '0; commit_wdata = '0;
    trace_en = 1'b1; rd_req = 1'b0; rd_idx = '0;
    tick(); tick();
    chk("rst.entries", 64'(entries), 64'd0);
    chk("rst.halted", 64'(halted), 64'd0);
    chk("rst.cycles", 64'(cycle_count), 64'd0);
    chk("rst.instrs", 64'(instr_count), 64'd0);
    chk("rst.rd_valid", 64'(rd_valid), 64'd0);
    reset = 1'b0;

    // Five commits, then reads at the ends and just past the fill level.
    for (int i = 0; i < 5; i++) commit(64'(i * 4), ADDI);
    chk("t1.entries", 64'(entries), 64'd5);
    chk("t1.overflow", 64'(overflow), 64'd0);
    chk("t1.instrs", 64'(instr_count), 64'd5);
    read(0); chk_hit("t1.rd0", 64'd0, ADDI);
    tick();
    chk("t1.valid_drop", 64'(rd_valid), 64'd0);
    read(4); chk_hit("t1.rd4", 64'd16, ADDI);
    read(5);
    chk("t1.rd5.valid", 64'(rd_valid), 64'd1);
    chk("t1.rd5.miss", 64'(rd_miss), 64'd1);
    chk("t1.rd5.pc", rd_pc, 64'd0);
    chk("t1.rd5.wdata", rd_wdata, 64'd0);

    // Wrap: 20 commits total, PCs 0..76.
    for (int i = 5; i < 20; i++) commit(64'(i * 4), ADDI);
    chk("t2.entries", 64'(entries), 64'd16);
    chk("t2.overflow", 64'(overflow), 64'd1);
    chk("t2.cycles", 64'(cycle_count), 64'(exp_cyc));
    read(0);  chk_hit("t2.rd0", 64'd16, ADDI);
    read(15); chk_hit("t2.rd15", 64'd76, ADDI);

    // Capture and read oldest in the same cycle: pre-capture oldest (pc 16) comes back.
    drive_commit(64'd80, ADDI);
    rd_req = 1'b1; rd_idx = '0;
    tick();
    commit_valid = 1'b0; rd_req = 1'b0;
    chk_hit("t5.same", 64'd16, ADDI);
    read(0);  chk_hit("t5.rd0", 64'd20, ADDI);
    read(15); chk_hit("t5.rd15", 64'd80, ADDI);

    // trace_en low for PCs 8, 16, 24 out of eight commits.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      trace_en = !(i == 2 || i == 4 || i == 6);
      commit(64'(i * 4), ADDI);
    end
    trace_en = 1'b1;
    tick(); tick();
    chk("t4.entries", 64'(entries), 64'd5);
    chk("t4.instrs", 64'(instr_count), 64'd8);
    chk("t4.cycles", 64'(cycle_count), 64'(exp_cyc));
    read(2); chk_hit("t4.rd2", 64'd12, ADDI);

    // Halt on two consecutive HALT words; an intervening ADDI clears the run.
    reset = 1'b1; tick(); reset = 1'b0;
    commit(64'd0, ADDI);
    commit(64'd4, HALT);
    commit(64'd8, ADDI);
    commit(64'd12, HALT);
    chk("t3.not_yet", 64'(halted), 64'd0);
    tick();
    chk("t3.idle_keeps_run", 64'(halted), 64'd0);
    commit(64'd16, HALT);
    exp_halted = 1'b1;
    chk("t3.halted", 64'(halted), 64'd1);
    chk("t3.halt_pc", halt_pc, 64'd16);
    chk("t3.instrs", 64'(instr_count), 64'd5);
    chk("t3.cycles", 64'(cycle_count), 64'(exp_cyc));
    commit(64'd20, ADDI);
    tick(); tick();
    chk("t3.frz.entries", 64'(entries), 64'd5);
    chk("t3.frz.instrs", 64'(instr_count), 64'd5);
    chk("t3.frz.cycles", 64'(cycle_count), 64'(exp_cyc));
    chk("t3.frz.halt_pc", halt_pc, 64'd16);
    read(4); chk_hit("t3.rd4", 64'd16, HALT);

    // Reset while halted with a read in flight and another in the reset cycle.
    read(1); chk_hit("t6.pre", 64'd4, HALT);
    reset = 1'b1; rd_req = 1'b1; rd_idx = 4'd1;
    tick();
    rd_req = 1'b0; reset = 1'b0;
    chk("t6.rd_valid", 64'(rd_valid), 64'd0);
    chk("t6.rd_pc", rd_pc, 64'd0);
    chk("t6.rd_instr", 64'(rd_instr), 64'd0);
    chk("t6.rd_rd", 64'(rd_rd), 64'd0);
    chk("t6.halted", 64'(halted), 64'd0);
    chk("t6.halt_pc", halt_pc, 64'd0);
    chk("t6.entries", 64'(entries), 64'd0);
    chk("t6.overflow", 64'(overflow), 64'd0);
    chk("t6.cycles", 64'(cycle_count), 64'd0);
    chk("t6.instrs", 64'(instr_count), 64'd0);
    tick();
    chk("t6.no_resp", 64'(rd_valid), 64'd0);
    commit(64'd100, ADDI);
    chk("t6.entries1", 64'(entries), 64'd1);
    read(0); chk_hit("t6.rd0", 64'd100, ADDI);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_trace_monitor.md
# cpu_trace_monitor

Synthesisable commit-trace and halt-detect block for the sequential and future pipelined RV64 cores. It sits beside `cpu_sequential`, snoops each retired instruction, and keeps a circular buffer of the last DEPTH commits. It detects the halt condition (a run of HALT_COUNT halt instructions) and keeps cycle and instruction counters. A bench or debug port reads the trace back by index after halt, so end-of-run dumps no longer need hierarchical peeks.

## Interface
- XLEN, 64, data/PC width
- DEPTH, 16, trace entries; power of two, ≥2
- HALT_INSTR, 32'h0000_0000, instruction word treated as halt
- HALT_COUNT, 1, consecutive committed HALT_INSTR words needed to halt; ≥1
- CNT_W, 32, cycle/instruction counter width
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- commit_valid  in  1  an instruction retires this cycle
- commit_pc  in  XLEN  PC of retiring instruction
- commit_instr  in  32  instruction word
- commit_we  in  1  retiring instruction writes rd
- commit_rd  in  5  destination register
- commit_wdata  in  XLEN  write-back value
- trace_en  in  1  1 = record commits into buffer
- rd_req  in  1  trace read request
- rd_idx  in  log2(DEPTH)  entry index, 0 = oldest held entry
- rd_valid  out  1  read response strobe
- rd_miss  out  1  rd_idx ≥ entry count at request
- rd_pc, rd_wdata  out  XLEN  entry fields
- rd_instr  out  32  entry instruction
- rd_we  out  1, rd_rd  out  5  entry write-back info
- entries  out  log2(DEPTH)+1  valid entries held
- overflow  out  1  sticky: at least one entry overwritten
- halted  out  1  sticky halt flag
- halt_pc  out  XLEN  PC of the commit that completed the halt run
- cycle_count, instr_count  out  CNT_W  counters

## Operation
- A capture happens when commit_valid && trace_en && !halted. The block writes {pc, instr, we, rd, wdata} at wr_ptr, and wr_ptr advances mod DEPTH.
- entries increments per capture and saturates at DEPTH. A capture when entries==DEPTH overwrites the oldest entry and sets overflow.
- instr_count increments on every commit_valid while !halted, regardless of trace_en. It saturates at all-ones.
- cycle_count increments every cycle while !halted, including the cycle that sets halted. It saturates at all-ones.
- Halt run counter: a commit_valid with commit_instr==HALT_INSTR increments the run. Any other valid commit clears the run to 0. Cycles without commit_valid leave the run unchanged.
- When the run reaches HALT_COUNT:
  - halted←1 and halt_pc←commit_pc.
  - The halting commit is itself captured if trace_en.
- After halt, captures and counters freeze and halted stays set until reset. Reads remain available.
- Read: physical index = (wr_ptr − entries + rd_idx) mod DEPTH, computed from state before any same-cycle capture.
  - If rd_idx ≥ entries: rd_miss=1 and all data outputs are 0.

## Timing
- Capture, counters and halt flag update on the clk edge of the commit cycle. They are visible the following cycle.
- Read latency is 1 cycle: rd_req at edge N gives rd_valid=1 for exactly the cycle after edge N, with data registered.
- Back-to-back rd_req is allowed, one response per request, in order.
- Simultaneous capture and read: the read returns pre-capture contents and indexing.
- Reset (synchronous, any time, including mid-read or mid-halt-run):
  - Clears wr_ptr, entries, run counter, overflow, halted, halt_pc, cycle_count, instr_count, rd_valid, rd_miss and all rd_* outputs to 0.
  - Buffer contents need not be cleared.
  - A rd_req in the reset cycle produces no response.

## Test plan
- Reset, then 5 captured commits with PCs 0,4,…,16 → entries=5, overflow=0. rd_idx=0 returns pc=0 one cycle later; rd_idx=4 returns pc=16; rd_idx=5 gives rd_miss=1 with data 0.
- DEPTH=16, 20 commits with PCs 0..76 → entries=16, overflow=1. rd_idx=0 returns pc=16; rd_idx=15 returns pc=76.
- HALT_COUNT=2, commits ADDI, 0x0, ADDI, 0x0, 0x0 at PCs 0..16 → halted rises after the 5th commit, halt_pc=16, instr_count=5. A further commit_valid changes nothing.
- trace_en=0 for 3 of 8 commits → entries=5, instr_count=8, cycle_count equals elapsed cycles up to the halt or sample point.
- Same-cycle capture and rd_req rd_idx=0 with entries=16 → the response returns the entry that is being overwritten (pre-capture oldest).
- Reset asserted while halted with an outstanding rd_req → next cycle all outputs are 0 and rd_valid=0. Subsequent commits capture from wr_ptr=0.
